dmem_access_ctrl: RTL and testbench
===================================

# dmem_access_ctrl

Multi-cycle load/store initiator sitting between the core's execute stage and the word-organised data memory. It accepts one byte/half/word load or store request at a time, drives the memory's word-indexed read/write port, performs read-modify-write for sub-word stores, and returns sign/zero-extended load data with an error flag for misaligned or illegal requests.

## Interface
Parameters:
- AW, 5, memory word-index width (memory holds 2^AW 32-bit words)

Ports:
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block idle and accepting; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal funct3; valid with rsp_valid
- mem_addr  out  AW  word index = latched req_addr[AW+1:2]
- mem_we  out  1  memory write enable
- mem_wd  out  32  memory write data
- mem_rd  in  32  memory read data, combinational from mem_addr

## Operation
- FSM states: IDLE, RD, WR, RESP.
- IDLE: req_ready=1. On req_valid, latch we, funct3, addr, wdata; classify:
  - illegal: load funct3 in {011,110,111}, store funct3 not in {000,001,010} -> RESP, err=1, no memory access.
  - misaligned: H/HU with addr[0]=1, W with addr[1:0]!=0 -> RESP, err=1, no memory access.
  - load -> RD; SW -> WR; SB/SH -> RD.
- RD: mem_we=0; capture mem_rd into 32-bit word buffer. Load -> RESP; store -> WR.
- WR: mem_we=1 for exactly this cycle; mem_wd = wdata (SW) or buffer with selected lanes replaced (SB/SH). -> RESP.
- RESP: rsp_valid=1, rsp_rdata/rsp_err registered values. -> IDLE.
- Load extraction, little-endian: lane = addr[1:0]; B/BU take byte at bits 8*lane+7:8*lane; H/HU take half at addr[1]; B/H sign-extend, BU/HU zero-extend.
- Store merge: SB writes wdata[7:0] to byte lane addr[1:0]; SH writes wdata[15:0] to half addr[1]; other lanes keep buffer contents.
- Address bits above AW+1 ignored: addresses wrap modulo 2^(AW+2) bytes.
- No response back-pressure; the core must sample rsp_valid when it pulses.

## Timing
- Request accepted in cycle T (IDLE, req_valid=1).
- Load: RD at T+1, rsp_valid at T+2.
- SW: WR at T+1 (write lands at T+1 edge), rsp_valid at T+2.
- SB/SH: RD at T+1, WR at T+2, rsp_valid at T+3.
- Error: rsp_valid at T+1; mem_we never asserted.
- req_valid outside IDLE ignored; back-to-back requests sustain one per 3 or 4 cycles.
- mem_addr driven from latched address from T+1 until the next accept; mem_we=0 in every state but WR.
- Reset (RST=0 at an edge) has priority over everything: state -> IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_we=0, mem_wd=0, mem_addr=0, buffer=0. An in-flight request is dropped with no response; a store aborted before WR never writes. req_ready=1 from the first cycle after reset deasserts.

## Structure
- Package dmem_pkg: funct3 width constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), FSM state encoding, lane helper constants.
- Sub-module dmem_lane_align: purely combinational; inputs word, addr[1:0], funct3, wdata; outputs extended load data and merged store word. FSM and registers live in the top.

## Test plan
- Memory word 3 = 0x8899AABB; LB at addr 0x0D -> rsp_rdata 0xFFFFFFAA at T+2, rsp_err=0; LBU same addr -> 0x000000AA.
- Word 2 = 0x11223344; SB wdata 0xFFFFFF5A at addr 0x0A -> mem_we only at T+2, mem_wd 0x115A3344; following LW at 0x08 returns 0x115A3344.
- SW 0xDEADBEEF at addr 0x84 (AW=5) -> write lands in word 1 at T+1 (wrap); LH at 0x06 -> 0xFFFFDEAD.
- LW at 0x02 and SH at 0x03 -> rsp_valid at T+1 with rsp_err=1, rsp_rdata=0, mem_we never high; load funct3=011 -> same error response.
- SH accepted, RST=0 during RD cycle -> no mem_we, no rsp_valid, all outputs 0 next cycle, req_ready=1 after release; memory word unchanged.
- req_valid held high across LW then LHU -> second accepted only at the IDLE after RESP; req_ready low in RD/RESP; two rsp_valid pulses exactly 3 cycles apart.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory load/store initiator.
// Width codes follow RV32I funct3; the FSM encoding is kept as plain constants.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam int LANE_W = 8;
  localparam int HALF_W = 16;

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] wdata;
  } req_t;

  // Request is rejected without touching memory if funct3 is illegal or misaligned.
  function automatic logic req_bad(input logic we, input logic [2:0] f3,
                                   input logic [1:0] lo);
    logic illegal;
    logic misalign;
    if (we) illegal = !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
    else    illegal = (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    misalign = ((f3 == F3_H || f3 == F3_HU) && lo[0]) ||
               (f3 == F3_W && lo != 2'b00);
    return illegal || misalign;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: load extraction with extension, and sub-word
// store merge into a previously read word. Purely combinational.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_word_o
);

  logic [LANE_W-1:0] byte_sel;
  logic [HALF_W-1:0] half_sel;

  always_comb begin
    byte_sel = word_i[8*addr_lo_i +: LANE_W];
    half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    ld_data_o = '0;
    case (funct3_i)
      F3_B:    ld_data_o = {{24{byte_sel[LANE_W-1]}}, byte_sel};
      F3_BU:   ld_data_o = {24'd0, byte_sel};
      F3_H:    ld_data_o = {{16{half_sel[HALF_W-1]}}, half_sel};
      F3_HU:   ld_data_o = {16'd0, half_sel};
      F3_W:    ld_data_o = word_i;
      default: ld_data_o = '0;
    endcase
  end

  // Untouched lanes keep the read-back contents of the word.
  always_comb begin
    st_word_o = word_i;
    case (funct3_i)
      F3_B: st_word_o[8*addr_lo_i +: LANE_W] = wdata_i[LANE_W-1:0];
      F3_H: begin
        if (addr_lo_i[1]) st_word_o[31:16] = wdata_i[HALF_W-1:0];
        else              st_word_o[15:0]  = wdata_i[HALF_W-1:0];
      end
      default: st_word_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Multi-cycle load/store initiator: one request at a time, read-modify-write
// for sub-word stores, extended load data and an error flag on completion.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [31:0]   mem_wd,
  input  logic [31:0]   mem_rd
);

  logic [1:0]    state_q, state_d;
  req_t          req_q, req_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   buf_q, buf_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [31:0]   align_word;
  logic [31:0]   ld_data;
  logic [31:0]   st_word;
  logic          unused_addr_hi;

  // Byte addresses wrap modulo the memory size; the high bits carry no meaning.
  assign unused_addr_hi = ^req_addr[31:AW+2];

  // Loads extract straight from the read port; stores merge into the buffer.
  assign align_word = (state_q == S_RD) ? mem_rd : buf_q;

  dmem_lane_align u_align (
    .word_i    (align_word),
    .addr_lo_i (addr_q[1:0]),
    .funct3_i  (req_q.f3),
    .wdata_i   (req_q.wdata),
    .ld_data_o (ld_data),
    .st_word_o (st_word)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    buf_d   = buf_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          req_d   = '{we: req_we, f3: req_funct3, wdata: req_wdata};
          addr_d  = req_addr[AW+1:0];
          rdata_d = '0;
          err_d   = 1'b0;
          if (req_bad(req_we, req_funct3, req_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (req_we && req_funct3 == F3_W) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        buf_d = mem_rd;
        if (req_q.we) begin
          state_d = S_WR;
        end else begin
          rdata_d = ld_data;
          state_d = S_RESP;
        end
      end
      S_WR: state_d = S_RESP;
      S_RESP: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      addr_q  <= '0;
      buf_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mem_addr  = addr_q[AW+1:2];
  assign mem_we    = (state_q == S_WR);
  assign mem_wd    = mem_we ? st_word : '0;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl with a behavioural word memory.
module tb_dmem_access_ctrl;

  localparam int AW = 5;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = 3'd0;
  logic [31:0]   req_addr = 32'd0;
  logic [31:0]   req_wdata = 32'd0;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wd;
  logic [31:0]   mem_rd;

  dmem_access_ctrl #(.AW(AW)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 CLK = ~CLK;

  logic [31:0] mem [2**AW];
  logic [31:0] ref_mem [2**AW];
  logic        tb_wr = 1'b0;
  logic [AW-1:0] tb_wa = '0;
  logic [31:0] tb_wd = 32'd0;

  assign mem_rd = mem[mem_addr];
  always @(posedge CLK) begin
    if (mem_we)     mem[mem_addr] <= mem_wd;
    else if (tb_wr) mem[tb_wa] <= tb_wd;
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  typedef struct { logic [31:0] rdata; logic err; int due; } rsp_t;
  typedef struct { int due; logic [AW-1:0] addr; logic [31:0] wd; } wr_t;
  rsp_t rsp_q[$];
  wr_t  wr_q[$];

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] a,
                                           input logic [2:0] f3);
    logic [31:0] s;
    s = w >> (8 * a);
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b100:  return {24'd0, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b101:  return {16'd0, s[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] a,
                                            input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] m;
    if (f3 == 3'b000)      m = 32'h0000_00FF << (8 * a);
    else if (f3 == 3'b001) m = 32'h0000_FFFF << (8 * a);
    else                   m = 32'hFFFF_FFFF;
    return (w & ~m) | ((d << (8 * a)) & m);
  endfunction

  function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [1:0] a);
    if (we) begin
      if (f3 == 3'b000) return 1'b0;
      if (f3 == 3'b001) return a[0];
      if (f3 == 3'b010) return a != 2'b00;
      return 1'b1;
    end
    if (f3 == 3'b000 || f3 == 3'b100) return 1'b0;
    if (f3 == 3'b001 || f3 == 3'b101) return a[0];
    if (f3 == 3'b010) return a != 2'b00;
    return 1'b1;
  endfunction

  // Predict the outcome of a request accepted in cycle t and queue it.
  task automatic predict(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int t);
    logic [AW-1:0] idx;
    logic [31:0] nw;
    idx = addr[AW+1:2];
    if (ref_err(we, f3, addr[1:0])) begin
      rsp_q.push_back('{rdata: 32'd0, err: 1'b1, due: t + 1});
    end else if (!we) begin
      rsp_q.push_back('{rdata: ref_load(ref_mem[idx], addr[1:0], f3), err: 1'b0, due: t + 2});
    end else begin
      nw = ref_store(ref_mem[idx], addr[1:0], f3, wd);
      ref_mem[idx] = nw;
      if (f3 == 3'b010) begin
        wr_q.push_back('{due: t + 1, addr: idx, wd: nw});
        rsp_q.push_back('{rdata: 32'd0, err: 1'b0, due: t + 2});
      end else begin
        wr_q.push_back('{due: t + 2, addr: idx, wd: nw});
        rsp_q.push_back('{rdata: 32'd0, err: 1'b0, due: t + 3});
      end
    end
  endtask

  task automatic wait_ready(output logic ok);
    int n = 0;
    @(negedge CLK);
    while (!req_ready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    ok = req_ready;
    if (!ok) check_eq("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic track);
    logic ok;
    wait_ready(ok);
    if (!ok) return;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    if (track) predict(we, f3, addr, wd, cyc);
    @(posedge CLK);
    #1 req_valid = 1'b0;
  endtask

  task automatic mem_init(input int idx, input logic [31:0] val);
    @(negedge CLK);
    tb_wr = 1'b1; tb_wa = AW'(idx); tb_wd = val;
    ref_mem[idx] = val;
    @(posedge CLK);
    #1 tb_wr = 1'b0;
  endtask

  // Scoreboard: responses and memory writes are compared against the queues.
  always @(negedge CLK) begin
    if (RST) begin
      if (rsp_valid) begin
        if (rsp_q.size() == 0) check_eq("rsp_unexpected", 32'd1, 32'd0);
        else begin
          rsp_t e;
          e = rsp_q.pop_front();
          check_eq("rsp_rdata", rsp_rdata, e.rdata);
          check_eq("rsp_err", 32'(rsp_err), 32'(e.err));
          check_eq("rsp_cycle", 32'(cyc), 32'(e.due));
        end
      end
      if (mem_we) begin
        if (wr_q.size() == 0) check_eq("mem_we_unexpected", 32'd1, 32'd0);
        else begin
          wr_t w;
          w = wr_q.pop_front();
          check_eq("wr_addr", 32'(mem_addr), 32'(w.addr));
          check_eq("wr_data", mem_wd, w.wd);
          check_eq("wr_cycle", 32'(cyc), 32'(w.due));
        end
      end
    end
  end

  initial begin
    logic ok;
    int t;
    logic [2:0] f3s [5];
    f3s[0] = 3'b000; f3s[1] = 3'b001; f3s[2] = 3'b010; f3s[3] = 3'b100; f3s[4] = 3'b101;

    RST = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_mem_wd", mem_wd, 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 2**AW; i++) mem_init(i, 32'h0101_0101 * i ^ 32'h5A00_00A5);
    mem_init(3, 32'h8899_AABB);
    mem_init(2, 32'h1122_3344);

    issue(1'b0, 3'b000, 32'h0000_000D, 32'd0, 1'b1);
    issue(1'b0, 3'b100, 32'h0000_000D, 32'd0, 1'b1);
    foreach (f3s[k])
      for (int a = 0; a < 4; a++) issue(1'b0, f3s[k], 32'h0000_000C + a, 32'd0, 1'b1);

    issue(1'b1, 3'b000, 32'h0000_000A, 32'hFFFF_FF5A, 1'b1);
    issue(1'b0, 3'b010, 32'h0000_0008, 32'd0, 1'b1);
    issue(1'b1, 3'b010, 32'h0000_0084, 32'hDEAD_BEEF, 1'b1);
    issue(1'b0, 3'b001, 32'h0000_0006, 32'd0, 1'b1);
    issue(1'b0, 3'b010, 32'h0000_0002, 32'd0, 1'b1);
    issue(1'b1, 3'b001, 32'h0000_0003, 32'h0000_1234, 1'b1);
    issue(1'b0, 3'b011, 32'h0000_0000, 32'd0, 1'b1);
    issue(1'b1, 3'b100, 32'h0000_0000, 32'h0000_0077, 1'b1);
    issue(1'b1, 3'b001, 32'hFFFF_FF9E, 32'h0000_CAFE, 1'b1);
    issue(1'b0, 3'b010, 32'h0000_001C, 32'd0, 1'b1);
    issue(1'b1, 3'b000, 32'h0000_0011, 32'h0000_00C3, 1'b1);
    issue(1'b0, 3'b010, 32'h0000_0010, 32'd0, 1'b1);

    // SH aborted by reset during its read cycle.
    issue(1'b1, 3'b001, 32'h0000_0012, 32'h0000_1234, 1'b0);
    check_eq("abort_in_rd_no_we", 32'(mem_we), 32'd0);
    RST = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check_eq("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("abort_rsp_rdata", rsp_rdata, 32'd0);
    check_eq("abort_mem_we", 32'(mem_we), 32'd0);
    check_eq("abort_mem_wd", mem_wd, 32'd0);
    check_eq("abort_mem_addr", 32'(mem_addr), 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    check_eq("abort_req_ready", 32'(req_ready), 32'd1);
    check_eq("abort_mem_intact", mem[4], ref_mem[4]);
    issue(1'b0, 3'b010, 32'h0000_0010, 32'd0, 1'b1);

    // req_valid held high across LW then LHU.
    wait_ready(ok);
    if (ok) begin
      t = cyc;
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_000C;
      predict(1'b0, 3'b010, 32'h0000_000C, 32'd0, t);
      @(posedge CLK);
      #1 req_funct3 = 3'b101; req_addr = 32'h0000_000E;
      @(negedge CLK);
      check_eq("b2b_ready_rd", 32'(req_ready), 32'd0);
      @(negedge CLK);
      check_eq("b2b_ready_resp", 32'(req_ready), 32'd0);
      @(negedge CLK);
      check_eq("b2b_ready_idle", 32'(req_ready), 32'd1);
      predict(1'b0, 3'b101, 32'h0000_000E, 32'd0, t + 3);
      @(posedge CLK);
      #1 req_valid = 1'b0;
    end

    for (int n = 0; n < 20 && (rsp_q.size() != 0 || wr_q.size() != 0); n++) @(negedge CLK);
    repeat (3) @(negedge CLK);
    check_eq("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    check_eq("wr_queue_drained", 32'(wr_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
